hatch_obi_mem_responder: RTL and testbench

OBI responder that terminates the core's data (or instruction) memory port with an internal word-addressed RAM. It accepts requests with a grant handshake and returns in-order responses after a fixed, configurable latency. It also flags errors for out-of-range addresses and unsupported atomics. The block sits between `hatch_core` and the SoC's local memory, and doubles as the bench memory model, with `stall_i` providing grant back-pressure.

---
 rtl/hatch_obi_mem_responder_if.sv | 25 ++
 rtl/hatch_obi_mem_responder.sv | 99 +++++++++
 tb/tb_hatch_obi_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hatch_obi_mem_responder_if.sv
// OBI data/instruction port bundle between an initiator (master) and
// hatch_obi_mem_responder (slave). Signal suffixes are from the responder's side.
interface hatch_obi_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [5:0]  atop_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        exokay_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, atop_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, exokay_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, atop_i,
        output gnt_o, rvalid_o, rdata_o, err_o, exokay_o
    );
endinterface

// File: rtl/hatch_obi_mem_responder.sv
// OBI responder backed by a word-addressed RAM: grant handshake, fixed-latency
// in-order responses, error responses for out-of-range addresses and atomics.
module hatch_obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                      clk_i,
    input logic                      rst_i,
    input logic                      stall_i,
    hatch_obi_mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        mem_q [MEM_WORDS];
    logic [CW-1:0]      outst_q, outst_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] rsp_err_q;
    logic [31:0]        rsp_rdata_q [LATENCY];

    logic          accept;
    logic          retire;
    logic          in_range;
    logic          req_err;
    logic [AW-1:0] widx;
    logic          unused_addr_lsb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

    // BASE_ADDR is aligned to the RAM size, so the range check is an upper-bit compare.
    assign in_range        = (bus.addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign widx            = bus.addr_i[AW+1:2];
    assign req_err         = !in_range || (bus.atop_i != 6'd0);
    assign unused_addr_lsb = ^bus.addr_i[1:0];

    assign bus.gnt_o = bus.req_i && !stall_i && (outst_q < CW'(MAX_OUTSTANDING));
    assign accept    = bus.gnt_o;

    // A transaction stops counting once its valid enters the output stage, which
    // lets gnt_o reopen in the same cycle its response is presented.
    generate
        if (LATENCY == 1) begin : g_retire_direct
            assign retire = accept;
        end else begin : g_retire_pipe
            assign retire = vld_q[LATENCY-2];
        end
    endgenerate

    always_comb begin
        outst_d  = outst_q + CW'(accept) - CW'(retire);
        vld_d    = vld_q << 1;
        vld_d[0] = accept;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
            vld_q   <= '0;
        end else begin
            outst_q <= outst_d;
            vld_q   <= vld_d;
        end
    end

    // Stage 0: capture response at the grant edge; later stages shift toward the outputs.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rsp_err_q[0]   <= req_err;
            rsp_rdata_q[0] <= (bus.we_i || req_err) ? 32'h0 : mem_q[widx];
        end
        for (int s = LATENCY - 1; s > 0; s--) begin
            rsp_err_q[s]   <= rsp_err_q[s-1];
            rsp_rdata_q[s] <= rsp_rdata_q[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && bus.we_i && !req_err) begin
            mem_q[widx] <= merge_bytes(mem_q[widx], bus.wdata_i, bus.be_i);
        end
    end

    // Output stage: data registers are not reset, so outputs are qualified by valid.
    assign bus.rvalid_o = vld_q[LATENCY-1];
    assign bus.err_o    = vld_q[LATENCY-1] && rsp_err_q[LATENCY-1];
    assign bus.rdata_o  = vld_q[LATENCY-1] ? rsp_rdata_q[LATENCY-1] : 32'h0;
    assign bus.exokay_o = 1'b0;
endmodule

// File: tb/tb_hatch_obi_mem_responder.sv
// Bench for hatch_obi_mem_responder: three instances (LATENCY 1/3/4) share one
// stimulus bus selected by 'sel'; directed scenarios plus a randomized model check.
module tb_hatch_obi_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_next = 1'b1;
    logic        stall = 1'b0, req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [5:0]  atop = 6'h0;
    int          sel = 1;

    logic        obs_gnt, obs_rv, obs_err, obs_exo;
    logic [31:0] obs_rd;
    logic        s_gnt, s_rv, s_err, s_exo;
    logic [31:0] s_rd;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] B4 = 32'h8000_0000;

    hatch_obi_mem_responder_if bus1 ();
    hatch_obi_mem_responder_if bus3 ();
    hatch_obi_mem_responder_if bus4 ();

    assign bus1.req_i = req && (sel == 1);
    assign bus3.req_i = req && (sel == 3);
    assign bus4.req_i = req && (sel == 4);
    assign bus1.addr_i = addr;  assign bus3.addr_i = addr;  assign bus4.addr_i = addr;
    assign bus1.we_i = we;      assign bus3.we_i = we;      assign bus4.we_i = we;
    assign bus1.be_i = be;      assign bus3.be_i = be;      assign bus4.be_i = be;
    assign bus1.wdata_i = wdata; assign bus3.wdata_i = wdata; assign bus4.wdata_i = wdata;
    assign bus1.atop_i = atop;  assign bus3.atop_i = atop;  assign bus4.atop_i = atop;

    hatch_obi_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(1))
        u_l1 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bus1));
    hatch_obi_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2))
        u_l3 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bus3));
    hatch_obi_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(B4), .LATENCY(4), .MAX_OUTSTANDING(2))
        u_l4 (.clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bus4));

    always_comb begin
        obs_gnt = bus4.gnt_o; obs_rv = bus4.rvalid_o; obs_rd = bus4.rdata_o;
        obs_err = bus4.err_o; obs_exo = bus4.exokay_o;
        if (sel == 1) begin
            obs_gnt = bus1.gnt_o; obs_rv = bus1.rvalid_o; obs_rd = bus1.rdata_o;
            obs_err = bus1.err_o; obs_exo = bus1.exokay_o;
        end else if (sel == 3) begin
            obs_gnt = bus3.gnt_o; obs_rv = bus3.rvalid_o; obs_rd = bus3.rdata_o;
            obs_err = bus3.err_o; obs_exo = bus3.exokay_o;
        end
    end

    // One bus cycle: drive at negedge, sample 1ns later, then let the rising edge happen.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [5:0] at, input logic st);
        @(negedge clk);
        rst = rst_next; req = r; we = w; addr = a; be = b; wdata = d; atop = at; stall = st;
        #1;
        s_gnt = obs_gnt; s_rv = obs_rv; s_rd = obs_rd; s_err = obs_err; s_exo = obs_exo;
        @(posedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 6'h0, 1'b0);
    endtask

    task automatic test_reset();
        int ids[3] = '{1, 3, 4};
        rst_next = 1'b1;
        foreach (ids[i]) begin
            sel = ids[i];
            idle();
            total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", sel, s_rv); end
            total++; if (s_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b expected 0", sel, s_err); end
            total++; if (s_rd !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h expected 0", sel, s_rd); end
            total++; if (s_exo !== 1'b0) begin bad++; $display("FAIL reset_exokay[%0d]: got %b expected 0", sel, s_exo); end
            total++; if (s_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_noreq[%0d]: got %b expected 0", sel, s_gnt); end
        end
        sel = 1;
        cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b1);
        total++; if (s_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_stall: got %b expected 0", s_gnt); end
        cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt_formula: got %b expected 1", s_gnt); end
        rst_next = 1'b0;
        idle();
        total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL reset_drop_rvalid: got %b expected 0", s_rv); end
        idle();
    endtask

    task automatic test_write_read();
        sel = 1;
        cycle(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt: got %b expected 1", s_gnt); end
        cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt: got %b expected 1", s_gnt); end
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'h0}) begin bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", s_rv, s_err, s_rd); end
        idle();
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rd_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", s_rv, s_err, s_rd); end
        idle();
        total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL rd_single: got %b expected 0", s_rv); end
    endtask

    task automatic test_partial_write();
        sel = 1;
        cycle(1'b1, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 6'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h12, 4'h0, 32'hFFFF_FFFF, 6'h0, 1'b0);
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'hDE22_BE44}) begin bad++; $display("FAIL partial_rd: got v=%b e=%b d=%h expected d=de22be44", s_rv, s_err, s_rd); end
        cycle(1'b1, 1'b0, 32'h13, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'h0}) begin bad++; $display("FAIL be0_wr_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", s_rv, s_err, s_rd); end
        idle();
        total++; if ({s_rv, s_rd} !== {1'b1, 32'hDE22_BE44}) begin bad++; $display("FAIL be0_unchanged: got v=%b d=%h expected d=de22be44", s_rv, s_rd); end
    endtask

    task automatic test_errors();
        sel = 1;
        cycle(1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 6'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL oor_gnt: got %b expected 1", s_gnt); end
        cycle(1'b1, 1'b1, 32'h20, 4'hF, 32'h0BAD_BEEF, 6'h20, 1'b0);
        total++; if ({s_rv, s_err, s_rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL oor_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0", s_rv, s_err, s_rd); end
        cycle(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if ({s_rv, s_err, s_rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL atop_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0", s_rv, s_err, s_rd); end
        cycle(1'b1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'hCAFE_F00D}) begin bad++; $display("FAIL atop_no_write: got v=%b e=%b d=%h expected d=cafef00d", s_rv, s_err, s_rd); end
        idle();
        total++; if ({s_rv, s_err, s_rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL high_addr_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0", s_rv, s_err, s_rd); end
        idle();
    endtask

    task automatic test_stall();
        sel = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b1);
            total++; if ({s_gnt, s_rv} !== 2'b00) begin bad++; $display("FAIL stall_gnt[%0d]: got gnt=%b rv=%b expected 0 0", i, s_gnt, s_rv); end
        end
        cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL stall_release_gnt: got %b expected 1", s_gnt); end
        idle();
        total++; if ({s_rv, s_rd} !== {1'b1, 32'hDE22_BE44}) begin bad++; $display("FAIL stall_rsp: got v=%b d=%h expected d=de22be44", s_rv, s_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};
        logic        eg[8]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        ev[8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ed[8];
        sel = 3;
        foreach (vals[i]) begin
            cycle(1'b1, 1'b1, 32'(4 * i), 4'hF, vals[i], 6'h0, 1'b0);
            repeat (3) idle();
        end
        ed = '{32'h0, 32'h0, 32'h0, vals[0], vals[1], 32'h0, vals[2], 32'h0};
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 6'h0, 1'b0);
            else if (c == 1) cycle(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 6'h0, 1'b0);
            else if (c <= 3) cycle(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 6'h0, 1'b0);
            else             idle();
            total++; if (s_gnt !== eg[c]) begin bad++; $display("FAIL b2b_gnt[c%0d]: got %b expected %b", c, s_gnt, eg[c]); end
            total++; if (s_rv !== ev[c] || (ev[c] && s_rd !== ed[c])) begin
                bad++; $display("FAIL b2b_rsp[c%0d]: got v=%b d=%h expected v=%b d=%h", c, s_rv, s_rd, ev[c], ed[c]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        sel = 4;
        cycle(1'b1, 1'b1, B4 + 32'h8, 4'hF, 32'h0F0F_0F0F, 6'h0, 1'b0);
        repeat (4) idle();
        cycle(1'b1, 1'b1, B4 + 32'h8, 4'hF, 32'h5A5A_A5A5, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL mid_wr_gnt: got %b expected 1", s_gnt); end
        cycle(1'b1, 1'b0, B4, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL mid_rd_gnt: got %b expected 1", s_gnt); end
        rst_next = 1'b1;
        cycle(1'b1, 1'b0, B4 + 32'h8, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b0) begin bad++; $display("FAIL mid_full_gnt: got %b expected 0", s_gnt); end
        rst_next = 1'b0;
        cycle(1'b1, 1'b0, B4 + 32'h8, 4'h0, 32'h0, 6'h0, 1'b0);
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL post_reset_gnt: got %b expected 1", s_gnt); end
        for (int i = 0; i < 3; i++) begin
            idle();
            total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL mid_dropped_rvalid[%0d]: got %b expected 0", i, s_rv); end
        end
        idle();
        total++; if ({s_rv, s_err, s_rd} !== {2'b10, 32'h5A5A_A5A5}) begin bad++; $display("FAIL mid_write_kept: got v=%b e=%b d=%h expected d=5a5aa5a5", s_rv, s_err, s_rd); end
        idle();
        total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL mid_tail_rvalid: got %b expected 0", s_rv); end
    endtask

    typedef struct { int due; logic err; logic [31:0] rdata; bit chk; } rsp_t;

    // Reference: transactions are listed with their response cycle (grant + LATENCY);
    // a transaction counts as outstanding until its response cycle arrives.
    task automatic test_random();
        localparam int L = 3, M = 2, W = 64;
        logic [31:0] mm[W];
        bit          known[W];
        rsp_t        q[$];
        rsp_t        e;
        logic        r = 0, w = 0, st, egnt, erv;
        logic [31:0] a = 0, d = 0;
        logic [3:0]  b = 0;
        logic [5:0]  at = 0;
        bit          hold = 0;
        int          outs, sel_a, wi;
        sel = 3;
        foreach (known[i]) known[i] = 0;
        for (int t = 0; t < 640; t++) begin
            if (t >= 600) begin
                r = 0; hold = 0; st = 0;
            end else begin
                if (!hold) begin
                    r = ($urandom % 4) != 0;
                    w = $urandom % 2;
                    sel_a = $urandom % 16;
                    if (sel_a == 0)      a = 32'(4 * W) + ($urandom % 64);
                    else if (sel_a == 1) a = $urandom;
                    else                 a = 32'(4 * ($urandom % 16) + ($urandom % 4));
                    b  = ($urandom % 2) ? 4'hF : 4'($urandom);
                    d  = $urandom;
                    at = ($urandom % 10 == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
                end
                st = ($urandom % 4) == 0;
            end
            outs = 0;
            foreach (q[i]) if (q[i].due > t) outs++;
            egnt = r && !st && (outs < M);
            cycle(r, w, a, b, d, at, st);
            total++; if (s_gnt !== egnt) begin bad++; $display("FAIL rand_gnt[t%0d]: got %b expected %b", t, s_gnt, egnt); end
            erv = (q.size() > 0) && (q[0].due == t);
            total++; if (s_rv !== erv) begin bad++; $display("FAIL rand_rvalid[t%0d]: got %b expected %b", t, s_rv, erv); end
            if (erv) begin
                e = q.pop_front();
                total++; if (s_err !== e.err || (e.chk && s_rd !== e.rdata)) begin
                    bad++; $display("FAIL rand_rsp[t%0d]: got e=%b d=%h expected e=%b d=%h", t, s_err, s_rd, e.err, e.rdata);
                end
            end
            if (egnt) begin
                e.due = t + L;
                e.err = (a >= 32'(4 * W)) || (at != 6'h0);
                wi    = int'(a >> 2) % W;
                e.rdata = 32'h0; e.chk = 1;
                if (!e.err && !w) begin
                    e.rdata = mm[wi]; e.chk = known[wi];
                end
                if (!e.err && w) begin
                    for (int k = 0; k < 4; k++) if (b[k]) mm[wi][8*k +: 8] = d[8*k +: 8];
                    if (b == 4'hF) known[wi] = 1;
                end
                q.push_back(e);
            end
            hold = r && !egnt;
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending expected 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
